csr_ctrl: RTL
=============

Name: csr_ctrl

Overview:
Multi-cycle CSR/trap sequencer that initiates all traffic on the CSR register file's read/write port. It accepts one decoded CSR or trap op from EXU through a valid/ready handshake, then performs the required reads and writes. It returns the rd writeback value, or a PC redirect for ECALL/MRET, to WBU through a second valid/ready handshake. It is the only driver of the CSR file's csr_read_addr, csr_write, csr_write_addr and csr_data.

Parameters:
CSR_DIG, 12, CSR address width
MSTATUS_A, 12'h300, mstatus address
MTVEC_A, 12'h305, mtvec address
MEPC_A, 12'h341, mepc address

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  op offered by EXU
in_ready  out  1  controller can accept an op
op  in  3  0 CSRRW, 1 CSRRS, 2 CSRRC, 3 ECALL, 4 MRET, 5-7 illegal
csr_addr  in  CSR_DIG  target CSR for ops 0-2
src  in  32  rs1 value or zero-extended uimm
src_zero  in  1  rs1/uimm field is 0 (suppresses write for CSRRS/CSRRC)
pc  in  32  PC of the instruction
out_valid  out  1  result available
out_ready  in  1  WBU accepts result
rd_wdata  out  32  old CSR value
rd_we  out  1  rd_wdata is valid for writeback
redirect  out  1  next PC = redirect_pc
redirect_pc  out  32  trap target / return address
csr_read_addr  out  CSR_DIG  to CSR file, combinational read
csr_rdata  in  32  from CSR file, same-cycle data
csr_write  out  1  CSR write strobe
csr_write_addr  out  CSR_DIG  CSR write address
csr_data  out  32  CSR write data

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset, state=IDLE; in_ready=0 during the reset cycle and 1 afterwards; out_valid, rd_we, redirect and csr_write are 0; rd_wdata, redirect_pc, csr_data and both address outputs are 0. Reset mid-sequence aborts the op with no further CSR write. A write already strobed in an earlier cycle stays committed.
- in_ready=1 only in IDLE. A handshake (in_valid & in_ready) latches op, csr_addr, src, src_zero and pc. The next state is chosen by op.
- States: IDLE, RD, WR, EC_EPC, EC_TVEC, MR_EPC, MR_ST_RD, MR_ST_WR, RESP.
- csr_write is asserted only in WR, EC_EPC and MR_ST_WR, for exactly one cycle each. In all other states it is 0.
- csr_read_addr holds the latched read target in RD, EC_TVEC, MR_EPC and MR_ST_RD; it is 0 elsewhere. csr_rdata is sampled at the end of those states.
- CSRRW/CSRRS/CSRRC:
  - IDLE -> RD: capture old=csr_rdata.
  - RD -> WR: new = src (RW), old|src (RS), old&~src (RC).
  - For RS/RC with src_zero=1, WR is skipped (RD -> RESP) and no write occurs.
  - Result: rd_wdata=old, rd_we=1, redirect=0.
  - Latency: accept at cycle 0, out_valid at cycle 3 (cycle 2 when WR is skipped).
- ECALL:
  - IDLE -> EC_EPC: write MEPC_A <- pc.
  - EC_EPC -> EC_TVEC: capture redirect_pc = csr_rdata & ~32'h3.
  - Then -> RESP with redirect=1, rd_we=0.
  - mcause is hardwired (11) in the CSR file and is not written.
- MRET:
  - IDLE -> MR_EPC: capture redirect_pc = mepc.
  - MR_EPC -> MR_ST_RD: capture ms.
  - MR_ST_RD -> MR_ST_WR: write mstatus <- ms with bit3(MIE)=ms[7], bit7(MPIE)=1, bits[12:11](MPP)=0.
  - Then -> RESP with redirect=1, rd_we=0.
- Illegal op: IDLE -> RESP directly with rd_we=0 and redirect=0. No CSR access occurs.
- RESP: out_valid=1. rd_wdata, rd_we, redirect and redirect_pc are held stable until out_ready. On out_valid & out_ready, go to IDLE and clear out_valid, rd_we and redirect. in_ready rises the next cycle, so there is no same-cycle accept and the throughput is one op per sequence.
- Accesses to unimplemented CSR addresses proceed normally: they read 0 and the write is dropped by the CSR file.
- Inputs op, csr_addr, src, src_zero and pc are ignored outside the accept cycle.

Test Plan:
- Reset, then CSRRW addr 0x305, src=0x80000100 -> csr_write one cycle at cycle 2 with addr 0x305, data 0x80000100; out_valid at cycle 3, rd_wdata=0, rd_we=1.
- mstatus=0x00000008, CSRRS 0x300 src=0x80 -> write 0x88, rd_wdata=0x8. Then CSRRC 0x300 src=0x8 -> write 0x80, rd_wdata=0x88. CSRRS with src_zero=1 -> no csr_write, out_valid at cycle 2.
- mtvec=0x80000103, ECALL pc=0x80000040 -> mepc written 0x80000040; redirect=1, redirect_pc=0x80000100, rd_we=0.
- mepc=0x80000044, mstatus=0x80, MRET -> mstatus written 0x80 with bit3=1, i.e. 0x88; redirect_pc=0x80000044.
- Hold out_ready=0 for 5 cycles in RESP -> outputs stable, in_ready=0, no CSR writes. Assert in_valid during RESP -> not accepted.
- Assert rst in the RD state of a CSRRW -> no csr_write ever, state IDLE, in_ready=1 after reset; op=6 -> out_valid with rd_we=0, redirect=0, no CSR access.

Source files
------------

// File: rtl/csr_ctrl_if.sv
// Bundles the EXU op handshake, the WBU result handshake and the CSR file port
// of the CSR/trap sequencer. The slave side is the sequencer, the master side its environment.
interface csr_ctrl_if #(
  parameter int CSR_DIG = 12
);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         op;
  logic [CSR_DIG-1:0] csr_addr;
  logic [31:0]        src;
  logic               src_zero;
  logic [31:0]        pc;

  logic               out_valid;
  logic               out_ready;
  logic [31:0]        rd_wdata;
  logic               rd_we;
  logic               redirect;
  logic [31:0]        redirect_pc;

  logic [CSR_DIG-1:0] csr_read_addr;
  logic [31:0]        csr_rdata;
  logic               csr_write;
  logic [CSR_DIG-1:0] csr_write_addr;
  logic [31:0]        csr_data;

  modport master (
    output in_valid, op, csr_addr, src, src_zero, pc, out_ready, csr_rdata,
    input  in_ready, out_valid, rd_wdata, rd_we, redirect, redirect_pc,
           csr_read_addr, csr_write, csr_write_addr, csr_data
  );

  modport slave (
    input  in_valid, op, csr_addr, src, src_zero, pc, out_ready, csr_rdata,
    output in_ready, out_valid, rd_wdata, rd_we, redirect, redirect_pc,
           csr_read_addr, csr_write, csr_write_addr, csr_data
  );
endinterface

// File: rtl/csr_ctrl.sv
// Multi-cycle CSR/trap sequencer: sole master of the CSR file read/write port,
// executing CSRRW/CSRRS/CSRRC, ECALL and MRET one op at a time.
module csr_ctrl #(
  parameter int                 CSR_DIG   = 12,
  parameter logic [CSR_DIG-1:0] MSTATUS_A = 12'h300,
  parameter logic [CSR_DIG-1:0] MTVEC_A   = 12'h305,
  parameter logic [CSR_DIG-1:0] MEPC_A    = 12'h341
) (
  input  logic    clk,
  input  logic    rst,
  csr_ctrl_if.slave bus
);

  localparam logic [2:0] OP_RW    = 3'd0;
  localparam logic [2:0] OP_RS    = 3'd1;
  localparam logic [2:0] OP_RC    = 3'd2;
  localparam logic [2:0] OP_ECALL = 3'd3;
  localparam logic [2:0] OP_MRET  = 3'd4;

  typedef enum logic [3:0] {
    IDLE, RD, WR, EC_EPC, EC_TVEC, MR_EPC, MR_ST_RD, MR_ST_WR, RESP
  } state_t;

  state_t state, state_nxt;

  logic [2:0]         op_r;
  logic [CSR_DIG-1:0] addr_r;
  logic [31:0]        src_r;
  logic               src_zero_r;
  logic [31:0]        pc_r;
  logic [31:0]        old_r;
  logic [31:0]        rpc_r;
  logic [31:0]        ms_r;
  logic               rd_we_r;
  logic               redirect_r;

  logic               in_ready_c;
  logic               accept;
  logic [CSR_DIG-1:0] rd_addr_c;
  logic               wr_c;
  logic [CSR_DIG-1:0] wr_addr_c;
  logic [31:0]        wr_data_c;

  function automatic logic [31:0] csr_update(input logic [2:0]  o,
                                             input logic [31:0] old,
                                             input logic [31:0] s);
    logic [31:0] r;
    case (o)
      OP_RW:   r = s;
      OP_RS:   r = old | s;
      default: r = old & ~s;
    endcase
    return r;
  endfunction

  // MIE <- MPIE, MPIE <- 1, MPP <- U
  function automatic logic [31:0] mret_status(input logic [31:0] ms);
    logic [31:0] r;
    r        = ms;
    r[3]     = ms[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b00;
    return r;
  endfunction

  assign in_ready_c = (state == IDLE) && !rst;
  assign accept     = bus.in_valid && in_ready_c;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (bus.op)
            OP_RW, OP_RS, OP_RC: state_nxt = RD;
            OP_ECALL:            state_nxt = EC_EPC;
            OP_MRET:             state_nxt = MR_EPC;
            default:             state_nxt = RESP;
          endcase
        end
      end
      RD:       state_nxt = (op_r != OP_RW && src_zero_r) ? RESP : WR;
      WR:       state_nxt = RESP;
      EC_EPC:   state_nxt = EC_TVEC;
      EC_TVEC:  state_nxt = RESP;
      MR_EPC:   state_nxt = MR_ST_RD;
      MR_ST_RD: state_nxt = MR_ST_WR;
      MR_ST_WR: state_nxt = RESP;
      RESP:     if (bus.out_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Operands are only meaningful after an accept, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_r       <= bus.op;
      addr_r     <= bus.csr_addr;
      src_r      <= bus.src;
      src_zero_r <= bus.src_zero;
      pc_r       <= bus.pc;
    end
    if (state == MR_ST_RD) ms_r <= bus.csr_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      old_r      <= '0;
      rpc_r      <= '0;
      rd_we_r    <= 1'b0;
      redirect_r <= 1'b0;
    end else begin
      if (accept) begin
        rd_we_r    <= (bus.op == OP_RW) || (bus.op == OP_RS) || (bus.op == OP_RC);
        redirect_r <= (bus.op == OP_ECALL) || (bus.op == OP_MRET);
      end else if (state == RESP && bus.out_ready) begin
        rd_we_r    <= 1'b0;
        redirect_r <= 1'b0;
      end
      if (state == RD)      old_r <= bus.csr_rdata;
      if (state == EC_TVEC) rpc_r <= bus.csr_rdata & ~32'h3;
      if (state == MR_EPC)  rpc_r <= bus.csr_rdata;
    end
  end

  // CSR port is driven purely from state; rst silences it so an aborted op never writes.
  always_comb begin
    rd_addr_c = '0;
    wr_c      = 1'b0;
    wr_addr_c = '0;
    wr_data_c = '0;
    if (!rst) begin
      case (state)
        RD:       rd_addr_c = addr_r;
        WR: begin
          wr_c      = 1'b1;
          wr_addr_c = addr_r;
          wr_data_c = csr_update(op_r, old_r, src_r);
        end
        EC_EPC: begin
          wr_c      = 1'b1;
          wr_addr_c = MEPC_A;
          wr_data_c = pc_r;
        end
        EC_TVEC:  rd_addr_c = MTVEC_A;
        MR_EPC:   rd_addr_c = MEPC_A;
        MR_ST_RD: rd_addr_c = MSTATUS_A;
        MR_ST_WR: begin
          wr_c      = 1'b1;
          wr_addr_c = MSTATUS_A;
          wr_data_c = mret_status(ms_r);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready       = in_ready_c;
  assign bus.out_valid      = (state == RESP) && !rst;
  assign bus.rd_we          = (state == RESP) && !rst && rd_we_r;
  assign bus.redirect       = (state == RESP) && !rst && redirect_r;
  assign bus.rd_wdata       = old_r;
  assign bus.redirect_pc    = rpc_r;
  assign bus.csr_read_addr  = rd_addr_c;
  assign bus.csr_write      = wr_c;
  assign bus.csr_write_addr = wr_addr_c;
  assign bus.csr_data       = wr_data_c;

endmodule
